gpio_pad_cfg_ctrl: RTL and testbench

- Sequences run-time mode changes for N sky130 GPIOv2 pad instances: drive mode (DM), OE_N and INP_DIS.
- Each change goes through a glitch-free isolate -> apply -> enable sequence, one pad at a time.
- Also synchronises the pads' IN outputs into the core clock domain.
- Sits between the core config logic and the pad-wrapper instances.

---
 rtl/gpio_pad_pkg.sv | 45 ++++
 rtl/gpio_pad_cfg_ctrl_in_sync.sv | 69 ++++++
 rtl/gpio_pad_cfg_ctrl.sv | 165 ++++++++++++++++
 tb/tb_gpio_pad_cfg_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/gpio_pad_pkg.sv
// Shared types and pad-control encodings for the GPIO pad config controller.
// Optional input debounce is enabled with GPIO_PAD_CFG_DEBOUNCE_EN.
package gpio_pad_pkg;

  typedef enum logic [1:0] {
    MODE_HIZ       = 2'd0,
    MODE_INPUT     = 2'd1,
    MODE_OUTPUT    = 2'd2,
    MODE_OUTPUT_OD = 2'd3
  } pad_mode_t;

  localparam logic [2:0] DM_HIZ    = 3'b000;
  localparam logic [2:0] DM_INPUT  = 3'b001;
  localparam logic [2:0] DM_OD     = 3'b011;
  localparam logic [2:0] DM_STRONG = 3'b110;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISOLATE,
    S_WAIT_ISO,
    S_APPLY,
    S_WAIT_DM,
    S_ENABLE,
    S_DONE
  } cfg_state_t;

  typedef struct packed {
    logic [2:0] dm;
    logic       oe_n;
    logic       inp_dis;
  } pad_ctrl_t;

  function automatic pad_ctrl_t mode_to_pad_ctrl(input pad_mode_t m);
    pad_ctrl_t c;
    c = '{dm: DM_HIZ, oe_n: 1'b1, inp_dis: 1'b1};
    case (m)
      MODE_INPUT:     c = '{dm: DM_INPUT,  oe_n: 1'b1, inp_dis: 1'b0};
      MODE_OUTPUT:    c = '{dm: DM_STRONG, oe_n: 1'b0, inp_dis: 1'b0};
      MODE_OUTPUT_OD: c = '{dm: DM_OD,     oe_n: 1'b0, inp_dis: 1'b0};
      default:        c = '{dm: DM_HIZ,    oe_n: 1'b1, inp_dis: 1'b1};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/gpio_pad_cfg_ctrl_in_sync.sv
// One pad's IN synchroniser, gated by INP_DIS.
// Optional debounce stage when GPIO_PAD_CFG_DEBOUNCE_EN is defined.
module gpio_in_sync
  import gpio_pad_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_inp_dis,
  input  logic i_pad_in,
  output logic o_sync
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = i_pad_in;
    sync_d = meta_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

`ifdef GPIO_PAD_CFG_DEBOUNCE_EN
  logic [3:0] cnt_q, cnt_d;
  logic       deb_q, deb_d;

  // Output follows only after 15 consecutive differing samples
  always_comb begin
    cnt_d = cnt_q;
    deb_d = deb_q;
    if (i_inp_dis) begin
      cnt_d = 4'd0;
      deb_d = 1'b0;
    end else if (sync_q != deb_q) begin
      if (cnt_q == 4'd14) begin
        deb_d = sync_q;
        cnt_d = 4'd0;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end else begin
      cnt_d = 4'd0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= 4'd0;
      deb_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      deb_q <= deb_d;
    end
  end

  assign o_sync = deb_q & ~i_inp_dis;
`else
  assign o_sync = sync_q & ~i_inp_dis;
`endif

endmodule

// File: rtl/gpio_pad_cfg_ctrl.sv
// Sequences isolate -> apply -> enable mode changes for N GPIO pads.
// Optional input debounce is enabled with GPIO_PAD_CFG_DEBOUNCE_EN.
module gpio_pad_cfg_ctrl
  import gpio_pad_pkg::*;
#(
  parameter int N_PADS     = 8,
  parameter int SETTLE_CYC = 4,
  localparam int PIDX_W    = (N_PADS > 1) ? $clog2(N_PADS) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_cfg_valid,
  output logic                  o_cfg_ready,
  input  logic [PIDX_W-1:0]     i_cfg_pad,
  input  logic [1:0]            i_cfg_mode,
  output logic                  o_busy,
  output logic                  o_cfg_err,
  output logic [3*N_PADS-1:0]   o_pad_dm,
  output logic [N_PADS-1:0]     o_pad_oe_n,
  output logic [N_PADS-1:0]     o_pad_inp_dis,
  output logic [2*N_PADS-1:0]   o_pad_mode,
  input  logic [N_PADS-1:0]     i_pad_in,
  output logic [N_PADS-1:0]     o_pad_in_sync
);

  cfg_state_t            state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [PIDX_W-1:0]     pad_q, pad_d;
  pad_mode_t             tgt_q, tgt_d;
  logic                  err_q, err_d;
  logic [3*N_PADS-1:0]   dm_q, dm_d;
  logic [N_PADS-1:0]     oe_n_q, oe_n_d;
  logic [N_PADS-1:0]     inp_dis_q, inp_dis_d;
  logic [2*N_PADS-1:0]   mode_q, mode_d;

  pad_mode_t cur_mode;
  pad_ctrl_t tgt_ctrl;
  logic      pad_ok;
  logic      do_iso, do_apply, do_enable;

  assign pad_ok   = {1'b0, i_cfg_pad} < (PIDX_W+1)'(N_PADS);
  assign tgt_ctrl = mode_to_pad_ctrl(tgt_q);

  always_comb begin
    cur_mode = MODE_HIZ;
    for (int k = 0; k < N_PADS; k++)
      if (PIDX_W'(k) == i_cfg_pad)
        cur_mode = pad_mode_t'(mode_q[2*k +: 2]);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pad_d     = pad_q;
    tgt_d     = tgt_q;
    err_d     = 1'b0;
    do_iso    = 1'b0;
    do_apply  = 1'b0;
    do_enable = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_cfg_valid) begin
          if (!pad_ok) begin
            err_d = 1'b1;
          end else begin
            pad_d   = i_cfg_pad;
            tgt_d   = pad_mode_t'(i_cfg_mode);
            state_d = (cur_mode == pad_mode_t'(i_cfg_mode))
                    ? S_DONE : S_ISOLATE;
          end
        end
      end
      S_ISOLATE: begin
        do_iso  = 1'b1;
        cnt_d   = 8'(SETTLE_CYC - 1);
        state_d = S_WAIT_ISO;
      end
      S_WAIT_ISO: begin
        if (cnt_q == 8'd0) state_d = S_APPLY;
        else               cnt_d   = cnt_q - 8'd1;
      end
      S_APPLY: begin
        do_apply = 1'b1;
        cnt_d    = 8'(SETTLE_CYC - 1);
        state_d  = S_WAIT_DM;
      end
      S_WAIT_DM: begin
        if (cnt_q == 8'd0) state_d = S_ENABLE;
        else               cnt_d   = cnt_q - 8'd1;
      end
      S_ENABLE: begin
        do_enable = 1'b1;
        state_d   = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Only the latched target pad is ever touched
  always_comb begin
    dm_d      = dm_q;
    oe_n_d    = oe_n_q;
    inp_dis_d = inp_dis_q;
    mode_d    = mode_q;
    for (int k = 0; k < N_PADS; k++) begin
      if (PIDX_W'(k) == pad_q) begin
        if (do_iso) begin
          oe_n_d[k]    = 1'b1;
          inp_dis_d[k] = 1'b1;
        end
        if (do_apply)
          dm_d[3*k +: 3] = tgt_ctrl.dm;
        if (do_enable) begin
          oe_n_d[k]        = tgt_ctrl.oe_n;
          inp_dis_d[k]     = tgt_ctrl.inp_dis;
          mode_d[2*k +: 2] = tgt_q;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 8'd0;
      pad_q     <= '0;
      tgt_q     <= MODE_HIZ;
      err_q     <= 1'b0;
      dm_q      <= '0;
      oe_n_q    <= '1;
      inp_dis_q <= '1;
      mode_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pad_q     <= pad_d;
      tgt_q     <= tgt_d;
      err_q     <= err_d;
      dm_q      <= dm_d;
      oe_n_q    <= oe_n_d;
      inp_dis_q <= inp_dis_d;
      mode_q    <= mode_d;
    end
  end

  assign o_cfg_ready   = (state_q == S_IDLE);
  assign o_busy        = (state_q != S_IDLE);
  assign o_cfg_err     = err_q;
  assign o_pad_dm      = dm_q;
  assign o_pad_oe_n    = oe_n_q;
  assign o_pad_inp_dis = inp_dis_q;
  assign o_pad_mode    = mode_q;

  for (genvar g = 0; g < N_PADS; g++) begin : g_sync
    gpio_in_sync u_sync (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_inp_dis (inp_dis_q[g]),
      .i_pad_in  (i_pad_in[g]),
      .o_sync    (o_pad_in_sync[g])
    );
  end

endmodule

// File: tb/tb_gpio_pad_cfg_ctrl.sv
// Directed bench for gpio_pad_cfg_ctrl (N_PADS=6, SETTLE_CYC=4).
// Debounce checks build when GPIO_PAD_CFG_DEBOUNCE_EN is defined.
module tb_gpio_pad_cfg_ctrl;

  localparam int N  = 6;
  localparam int S  = 4;
  localparam int PW = 3;

  logic           clk;
  logic           rst;
  logic           valid;
  logic           ready;
  logic [PW-1:0]  pad;
  logic [1:0]     mode;
  logic           busy;
  logic           err;
  logic [3*N-1:0] dm;
  logic [N-1:0]   oe_n;
  logic [N-1:0]   inp_dis;
  logic [2*N-1:0] pmode;
  logic [N-1:0]   pin;
  logic [N-1:0]   psync;

  int n_run  = 0;
  int n_fail = 0;

  gpio_pad_cfg_ctrl #(.N_PADS(N), .SETTLE_CYC(S)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_cfg_valid   (valid),
    .o_cfg_ready   (ready),
    .i_cfg_pad     (pad),
    .i_cfg_mode    (mode),
    .o_busy        (busy),
    .o_cfg_err     (err),
    .o_pad_dm      (dm),
    .o_pad_oe_n    (oe_n),
    .o_pad_inp_dis (inp_dis),
    .o_pad_mode    (pmode),
    .i_pad_in      (pin),
    .o_pad_in_sync (psync)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit hit");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int p, input int m);
    valid = 1'b1;
    pad   = PW'(p);
    mode  = 2'(m);
    tick();
    valid = 1'b0;
  endtask

  task automatic wait_ready(input int maxc);
    for (int i = 0; i < maxc && !ready; i++) tick();
    check("ready_timeout", 32'(ready), 32'd1);
  endtask

  initial begin
    rst   = 1'b1;
    valid = 1'b0;
    pad   = '0;
    mode  = '0;
    pin   = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    check("rst_dm",      32'(dm),      32'h0);
    check("rst_oe_n",    32'(oe_n),    32'h3f);
    check("rst_inp_dis", 32'(inp_dis), 32'h3f);
    check("rst_mode",    32'(pmode),   32'h0);
    check("rst_ready",   32'(ready),   32'd1);
    check("rst_busy",    32'(busy),    32'd0);
    check("rst_err",     32'(err),     32'd0);
    for (int i = 0; i < 4; i++) begin
      pin = (i % 2 == 0) ? 6'h3f : 6'h00;
      tick();
      tick();
      tick();
      check("sync_gated", 32'(psync), 32'h0);
    end
    pin = '0;

    send(3, 1);
    wait_ready(20);
    check("p3in_dm",  32'(dm),      32'h200);
    check("p3in_dis", 32'(inp_dis), 32'h37);

    send(3, 2);
    check("c0_busy",  32'(busy),    32'd1);
    check("c0_ready", 32'(ready),   32'd0);
    check("c0_dis",   32'(inp_dis), 32'h37);
    tick();
    check("c1_dis",   32'(inp_dis), 32'h3f);
    check("c1_oe",    32'(oe_n),    32'h3f);
    check("c1_dm",    32'(dm),      32'h200);
    repeat (4) tick();
    check("c5_dm",    32'(dm),      32'h200);
    tick();
    check("c6_dm",    32'(dm),      32'hc00);
    repeat (4) tick();
    check("c10_oe",   32'(oe_n),    32'h3f);
    tick();
    check("c11_oe",   32'(oe_n),    32'h37);
    check("c11_dis",  32'(inp_dis), 32'h37);
    check("c11_mode", 32'(pmode),   32'h080);
    check("c11_busy", 32'(busy),    32'd1);
    tick();
    check("c12_ready", 32'(ready),  32'd1);
    check("c12_busy",  32'(busy),   32'd0);

    valid = 1'b1;
    pad   = 3'd7;
    mode  = 2'd1;
    tick();
    check("err7_pulse", 32'(err),   32'd1);
    check("err7_ready", 32'(ready), 32'd1);
    pad = 3'd6;
    tick();
    check("err6_pulse", 32'(err),   32'd1);
    check("err6_busy",  32'(busy),  32'd0);
    valid = 1'b0;
    tick();
    check("err_clear",  32'(err),   32'd0);
    check("err_dm",     32'(dm),    32'hc00);
    check("err_mode",   32'(pmode), 32'h080);

    send(1, 1);
    valid = 1'b1;
    pad   = 3'd4;
    mode  = 2'd3;
    repeat (11) tick();
    check("hold_mode",  32'(pmode), 32'h084);
    check("hold_dm",    32'(dm),    32'hc08);
    check("hold_ready", 32'(ready), 32'd0);
    tick();
    check("hold_idle",  32'(ready), 32'd1);
    tick();
    valid = 1'b0;
    check("hold_acc",   32'(busy),  32'd1);
    wait_ready(20);
    check("hold_dm2",   32'(dm),      32'h3c08);
    check("hold_oe2",   32'(oe_n),    32'h27);
    check("hold_dis2",  32'(inp_dis), 32'h25);
    check("hold_mode2", 32'(pmode),   32'h384);

    send(4, 3);
    check("same_busy", 32'(busy), 32'd1);
    check("same_dm",   32'(dm),   32'h3c08);
    check("same_oe",   32'(oe_n), 32'h27);
    tick();
    check("same_ready", 32'(ready), 32'd1);
    check("same_mode",  32'(pmode), 32'h384);
    check("same_dis",   32'(inp_dis), 32'h25);

    send(0, 3);
    repeat (7) tick();
    check("wdm_dm",   32'(dm),   32'h3c0b);
    check("wdm_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_dm",    32'(dm),      32'h0);
    check("mrst_oe",    32'(oe_n),    32'h3f);
    check("mrst_dis",   32'(inp_dis), 32'h3f);
    check("mrst_mode",  32'(pmode),   32'h0);
    check("mrst_ready", 32'(ready),   32'd1);
    check("mrst_busy",  32'(busy),    32'd0);

    send(2, 1);
    wait_ready(20);
    check("p2_dis", 32'(inp_dis), 32'h3b);
    pin = 6'h24;
`ifdef GPIO_PAD_CFG_DEBOUNCE_EN
    repeat (5) tick();
    pin = 6'h00;
    repeat (25) tick();
    check("deb_glitch", 32'(psync), 32'h0);
    pin = 6'h24;
    repeat (16) tick();
    check("deb_c16", 32'(psync), 32'h0);
    tick();
    check("deb_c17", 32'(psync), 32'h04);
`else
    tick();
    check("sync_c1", 32'(psync), 32'h0);
    tick();
    check("sync_c2", 32'(psync), 32'h04);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
